// File: rtl/as13_trace_fifo_if.sv
// as13_trace_fifo_if: valid/ready read channel carrying {ts, y} trace entries
interface as13_trace_fifo_if #(
   parameter int W = 25,
   parameter int TS_W = 8
);
   logic rd_valid;
   logic rd_ready;
   logic [TS_W+W-1:0] rd_data;
   modport master(output rd_valid, rd_data, input rd_ready);
   modport slave(input rd_valid, rd_data, output rd_ready);
endinterface

// File: rtl/as13_trace_fifo.sv
// as13_trace_fifo: change-triggered timestamped capture of as13 outputs into a FWFT FIFO
module as13_trace_fifo #(
   parameter int W = 25,
   parameter int TS_W = 8,
   parameter int DEPTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clear,
   input  logic [W-1:0] y_in,
   as13_trace_fifo_if.master rd,
   output logic [$clog2(DEPTH):0] count,
   output logic overflow,
   output logic [7:0] drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   logic [TS_W+W-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_n;
   logic [TS_W-1:0] ts;
   logic [W-1:0] last_y;
   logic prime, push, pop, full, accept, drop;
   logic [AW:0] count_n;
   logic [TS_W+W-1:0] word, head_n;
   assign rd.rd_valid = count != '0;
   // the head register is reloaded from the pushed word when that word lands at the new head slot
   always_comb begin
      word = {ts, y_in};
      push = en && (prime || y_in != last_y);
      pop = rd.rd_valid && rd.rd_ready;
      full = count == (AW+1)'(DEPTH);
      accept = push && (!full || pop);
      drop = push && full && !pop;
      rd_ptr_n = rd_ptr + AW'(pop);
      count_n = count + (AW+1)'(accept) - (AW+1)'(pop);
      head_n = (accept && rd_ptr_n == wr_ptr) ? word : mem[rd_ptr_n];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
         ts <= '0;
         last_y <= '0;
         prime <= 1'b1;
         overflow <= 1'b0;
         drop_cnt <= '0;
         rd.rd_data <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
         ts <= '0;
         prime <= 1'b1;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         rd_ptr <= rd_ptr_n;
         wr_ptr <= wr_ptr + AW'(accept);
         count <= count_n;
         if (en) begin
            ts <= ts + 1'b1;
            last_y <= y_in;
         end
         prime <= !en;
         overflow <= overflow | drop;
         drop_cnt <= drop_cnt + 8'(drop && drop_cnt != 8'hFF);
         if (count_n != '0) rd.rd_data <= head_n;
      end
   always_ff @(posedge clk)
      if (!rst && !clear && accept) mem[wr_ptr] <= word;
endmodule

// File: doc/as13_trace_fifo.md
Name: as13_trace_fifo

Overview:
- Downstream observer of the as13 controller.
- Samples the controller's 25 combinational outputs y1..y25 once per clock.
- Records a timestamped entry only when the output word changes.
- Entries sit in a small first-word-fall-through FIFO that a debug/bench reader drains over a valid/ready handshake.
- Used to capture micro-operation traces of the key-locked FSM for functional checking.

Parameters:
- W, 25, width of the sampled output word; y_in[k-1] carries yk.
- TS_W, 8, timestamp width in bits; the timestamp wraps modulo 2^TS_W.
- DEPTH, 8, number of FIFO entries; must be a power of two, minimum 2.

Ports:
- clk, input, 1, clock. The controller updates state on the falling edge; this block samples on the rising edge.
- rst, input, 1, reset, asynchronous, active-high.
- en, input, 1, capture enable.
- clear, input, 1, synchronous flush.
- y_in, input, W, controller outputs y1..y25.
- rd_ready, input, 1, reader accepts the head entry.
- rd_valid, output, 1, FIFO non-empty.
- rd_data, output, TS_W+W, head entry laid out as {ts, y}; ts occupies the MSBs.
- count, output, log2(DEPTH)+1, current occupancy.
- overflow, output, 1, sticky flag: at least one entry was dropped.
- drop_cnt, output, 8, number of dropped entries, saturating at 255.

Behaviour:
- Reset (rst=1, async) forces all of the following to 0:
  - rd_valid, rd_data, count, overflow, drop_cnt;
  - the timestamp counter ts, last_y, and both FIFO pointers.
  - The prime flag is set to 1.
- All other activity happens on the rising edge of clk.
- Priority is clear > capture/pop. When clear=1:
  - the FIFO empties and the pointers, count, ts, overflow and drop_cnt return to 0;
  - prime is set to 1;
  - no push or pop takes place that cycle.
- ts:
  - increments by 1 every rising edge while en=1 and holds while en=0;
  - wraps from 2^TS_W-1 to 0 silently.
- Capture request: on a rising edge with en=1, a push is requested when prime=1 or y_in != last_y.
  - The pushed entry is {ts (value before this edge's increment), y_in}.
  - last_y takes y_in and prime clears, even if the push is dropped.
- Falling edge of en sets prime=1, so the first sample after re-enable is always recorded.
- en=0: no capture, and last_y holds.
- Pop occurs when rd_valid && rd_ready. The head pointer advances, and rd_data presents the next entry in the same cycle as the pointer update (FWFT).
- rd_valid = (count != 0). There is no bypass: a word pushed into an empty FIFO becomes visible on rd_valid/rd_data one cycle after its capture edge.
- Push and pop in the same cycle:
  - both occur and count is unchanged;
  - this holds when full (pop frees the slot, push is accepted, no drop);
  - a push into an empty FIFO with rd_ready=1 still yields no pop, since rd_valid=0.
- Full (count=DEPTH) with a push requested and no pop:
  - the entry is discarded;
  - overflow is set (sticky until rst or clear);
  - drop_cnt increments, saturating at 255;
  - stored entries are not modified.
- Empty pop: impossible, because pops are gated by rd_valid; rd_ready while empty is ignored.
- Pointers are log2(DEPTH) bits and wrap naturally. count is maintained explicitly and ranges 0..DEPTH.
- rd_data is defined only while rd_valid=1; it holds the last head value otherwise.
- y_in is assumed stable at the rising edge, since the controller changes half a cycle earlier. No internal synchronisers.

Test Plan:
1. rst pulse, en=1, y_in=25'h0000400 (y11, state s1) held for 5 cycles → exactly one entry, {ts=8'h00, 25'h0000400}; rd_valid rises on cycle 1; count=1.
2. y_in changes on cycles 0, 3 and 4 (25'h0000400 → 25'h00000DA → 25'h0000100), rd_ready=1 → three entries read in order with ts 0, 3, 4; no entry for unchanged cycles.
3. DEPTH=8, rd_ready=0, 10 distinct consecutive words → count=8, overflow=1, drop_cnt=2; draining returns words 1..8 with ts 0..7.
4. FIFO full, rd_ready=1 and a new change in the same cycle → count stays 8, drop_cnt unchanged, new entry appears last on drain.
5. TS_W=4, en=1 from reset, first change at cycle 17 → entry ts=4'h1 (wrapped); en low 3 cycles then high with y unchanged → entry recorded (prime) with ts resumed from held value.
6. Mid-operation: 4 entries queued, overflow=1, assert clear for 1 cycle → count=0, rd_valid=0, overflow=0, drop_cnt=0, ts=0; repeat with async rst pulse between clock edges → outputs zero immediately.
